bist_controller: RTL and testbench
==================================

Name: bist_controller

Overview:
- Sequencer for the 1-bit full-adder BIST.
- Loads and steps the 3-bit LFSR test-pattern generator, muxes patterns onto the CUT inputs in test mode, and compares CUT outputs against an internally computed golden sum/carry.
- Reports done, pass/fail, mismatch count and first failing pattern.
- Sits between the top-level test request, the TPG and the full-adder CUT; in functional mode the CUT is driven from functional inputs.

Parameters:
- NUM_PATTERNS, 7, number of patterns compared per test run (≥1).
- FAIL_CNT_W, 3, width of the saturating mismatch counter.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  test request, sampled each cycle, honoured only in IDLE or DONE
- func_a, func_b, func_cin  input  1 each  functional-mode CUT inputs
- tpg_pattern  input  3  current TPG state; bit2→a, bit1→b, bit0→cin
- tpg_load  output  1  one-cycle request to load the TPG seed
- tpg_step  output  1  advance TPG one state at next edge
- cut_a, cut_b, cut_cin  output  1 each  CUT inputs (combinational mux)
- cut_sum, cut_cout  input  1 each  CUT responses (combinational CUT)
- test_mode  output  1  high in LOAD, SETTLE, RUN
- busy  output  1  high in LOAD, SETTLE, RUN
- done  output  1  high in DONE
- pass  output  1  registered; 1 only in DONE with zero mismatches
- fail_count  output  FAIL_CNT_W  mismatches in the last/current run
- first_fail_pattern  output  3  tpg_pattern at the first mismatch; 0 if none

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN, DONE (binary encoded, registered).
- Reset (sync): state=IDLE; pass=0, fail_count=0, first_fail_pattern=0, pattern counter=0. Reset takes effect regardless of state, including mid-RUN: test_mode drops at the same edge and the run is discarded.
- CUT mux: cut_{a,b,cin} = test_mode ? tpg_pattern[2:0] : func_{a,b,cin}. No register.
- Golden: exp_sum = a^b^cin; exp_cout = majority(a,b,cin), taken from tpg_pattern. Mismatch = {cut_cout,cut_sum} != {exp_cout,exp_sum}.
- IDLE: outputs inactive. start=1 → LOAD. On that edge clear fail_count, first_fail_pattern, pass and the counter.
- LOAD: tpg_load=1 for exactly one cycle → SETTLE.
- SETTLE: one wait cycle so the TPG presents the seed; no compare → RUN.
- RUN: one compare per cycle.
  - On a mismatch, fail_count increments, saturating at 2^FAIL_CNT_W−1.
  - On the first mismatch of a run, capture tpg_pattern into first_fail_pattern.
  - Counter increments each RUN cycle.
  - tpg_step=1 in every RUN cycle except the last compare (counter==NUM_PATTERNS−1). Exactly NUM_PATTERNS−1 step pulses per run.
  - After the last compare → DONE.
- DONE: done=1; pass=(final fail_count==0), registered on the RUN→DONE edge. Results hold until start or reset. start=1 → LOAD and clears results as in IDLE.
- start while busy: ignored, with no effect on the count or results.
- Latency: start high at edge N gives LOAD from N+1, SETTLE N+2, RUN N+3..N+2+NUM_PATTERNS, and done high from N+3+NUM_PATTERNS (cycle 10 after start for the default).
- tpg_load and tpg_step are never high in the same cycle. Both are 0 outside LOAD/RUN.

Test Plan:
- Reset and idle: assert reset 2 cycles, then drive func_a=1, func_b=0, func_cin=1 → test_mode=0, busy=0, done=0, pass=0, fail_count=0, cut_{a,b,cin}=1,0,1.
- Fault-free run: behavioural TPG (seed 001, x^3+x+1) plus correct adder; pulse start → one tpg_load, 6 tpg_step pulses, 7 compares, done 10 cycles after start, pass=1, fail_count=0, first_fail_pattern=000.
- Sum stuck-at-0 CUT: same sequence → fail_count=4 (patterns 001,010,100,111), pass=0, first_fail_pattern=001.
- Cout stuck-at-1 CUT → fail_count=3, pass=0, first_fail_pattern=001. With FAIL_CNT_W=1 and sum stuck-at-0 → fail_count saturates at 1.
- start pulses during LOAD/SETTLE/RUN → ignored, done still exactly 10 cycles after the original start. start in DONE after a failing run, with a good CUT → results cleared on the next edge and the new run gives pass=1.
- Reset asserted in the 4th RUN cycle → next edge: IDLE, test_mode=0, tpg_step=0, fail_count=0. A later start runs the full 7 compares normally.

Source files
------------

// File: rtl/bist_controller.sv
// Sequencer for the 1-bit full-adder BIST: drives the LFSR TPG, muxes patterns
// onto the CUT and scores its responses against a golden sum/carry.
module bist_controller #(
  parameter int unsigned NUM_PATTERNS = 7,
  parameter int unsigned FAIL_CNT_W   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  func_a,
  input  logic                  func_b,
  input  logic                  func_cin,
  input  logic [2:0]            tpg_pattern,
  output logic                  tpg_load,
  output logic                  tpg_step,
  output logic                  cut_a,
  output logic                  cut_b,
  output logic                  cut_cin,
  input  logic                  cut_sum,
  input  logic                  cut_cout,
  output logic                  test_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [2:0]            first_fail_pattern
);

  localparam int unsigned CNT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [2:0]            first_fail_q, first_fail_d;
  logic                  pass_q, pass_d;

  logic exp_sum, exp_cout, mismatch, last_cmp, accept_start;

  assign exp_sum  = ^tpg_pattern;
  assign exp_cout = (tpg_pattern[2] & tpg_pattern[1]) |
                    (tpg_pattern[2] & tpg_pattern[0]) |
                    (tpg_pattern[1] & tpg_pattern[0]);
  assign mismatch = {cut_cout, cut_sum} != {exp_cout, exp_sum};
  assign last_cmp = (cnt_q == LAST_CNT);
  assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SETTLE;
      SETTLE:  state_d = RUN;
      RUN:     if (last_cmp) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Result datapath; a zero fail count doubles as "no mismatch seen yet"
  // because the counter saturates and never wraps back to zero.
  always_comb begin
    cnt_d        = cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    if (accept_start) begin
      cnt_d        = '0;
      fail_cnt_d   = '0;
      first_fail_d = '0;
      pass_d       = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (mismatch) begin
        if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        if (fail_cnt_q == '0) first_fail_d = tpg_pattern;
      end
      if (last_cmp) pass_d = (fail_cnt_d == '0);
    end
  end

  always_comb begin
    test_mode = (state_q == LOAD) || (state_q == SETTLE) || (state_q == RUN);
    busy      = test_mode;
    done      = (state_q == DONE);
    tpg_load  = (state_q == LOAD);
    tpg_step  = (state_q == RUN) && !last_cmp;
  end

  assign cut_a   = test_mode ? tpg_pattern[2] : func_a;
  assign cut_b   = test_mode ? tpg_pattern[1] : func_b;
  assign cut_cin = test_mode ? tpg_pattern[0] : func_cin;

  assign pass               = pass_q;
  assign fail_count         = fail_cnt_q;
  assign first_fail_pattern = first_fail_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: behavioural TPG and full-adder CUT with selectable
// faults, plus a second instance with a 1-bit fail counter to observe saturation.
module tb_bist_controller;
  localparam int unsigned NP = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic func_a = 1'b0, func_b = 1'b0, func_cin = 1'b0;
  logic [2:0] tpg = 3'b000;

  logic tpg_load, tpg_step, cut_a, cut_b, cut_cin, cut_sum, cut_cout;
  logic test_mode, busy, done, pass;
  logic [2:0] fail_count, ffp;

  logic tpg_load1, tpg_step1, cut_a1, cut_b1, cut_cin1, cut_sum1, cut_cout1;
  logic test_mode1, busy1, done1, pass1;
  logic [0:0] fail_count1;
  logic [2:0] ffp1;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int mode = 0;
  logic [7:0] fmask = 8'h00;

  bist_controller #(.NUM_PATTERNS(NP), .FAIL_CNT_W(3)) dut (
    .clock(clock), .reset(reset), .start(start),
    .func_a(func_a), .func_b(func_b), .func_cin(func_cin),
    .tpg_pattern(tpg), .tpg_load(tpg_load), .tpg_step(tpg_step),
    .cut_a(cut_a), .cut_b(cut_b), .cut_cin(cut_cin),
    .cut_sum(cut_sum), .cut_cout(cut_cout),
    .test_mode(test_mode), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_pattern(ffp)
  );

  bist_controller #(.NUM_PATTERNS(NP), .FAIL_CNT_W(1)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .func_a(func_a), .func_b(func_b), .func_cin(func_cin),
    .tpg_pattern(tpg), .tpg_load(tpg_load1), .tpg_step(tpg_step1),
    .cut_a(cut_a1), .cut_b(cut_b1), .cut_cin(cut_cin1),
    .cut_sum(cut_sum1), .cut_cout(cut_cout1),
    .test_mode(test_mode1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fail_count1), .first_fail_pattern(ffp1)
  );

  always #5 clock = ~clock;

  // TPG: seed 001, x^3+x+1, stepped by the primary instance
  always @(posedge clock) begin
    if (tpg_load) tpg <= 3'b001;
    else if (tpg_step) tpg <= {tpg[1:0], tpg[2] ^ tpg[1]};
  end

  // Primary CUT: 0 good, 1 sum stuck-at-0, 2 cout stuck-at-1, 3 sum flipped on masked patterns
  logic [1:0] good, resp;
  always_comb begin
    good = {1'b0, cut_a} + {1'b0, cut_b} + {1'b0, cut_cin};
    resp = good;
    case (mode)
      1: resp[0] = 1'b0;
      2: resp[1] = 1'b1;
      3: if (fmask[{cut_a, cut_b, cut_cin}]) resp = good ^ 2'b01;
      default: resp = good;
    endcase
    {cut_cout, cut_sum} = resp;
  end

  assign cut_sum1  = 1'b0;
  assign cut_cout1 = (cut_a1 & cut_b1) | (cut_a1 & cut_cin1) | (cut_b1 & cut_cin1);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: walk the pattern list the TPG produces and score it against the fault
  function automatic void model(input int m, input logic [7:0] mk,
                                output int cnt, output logic [2:0] first);
    logic [2:0] s;
    int ones;
    logic bad;
    s = 3'b001;
    cnt = 0;
    first = 3'b000;
    for (int i = 0; i < NP; i++) begin
      ones = int'(s[2]) + int'(s[1]) + int'(s[0]);
      case (m)
        1: bad = (ones % 2) == 1;
        2: bad = ones < 2;
        3: bad = mk[s];
        default: bad = 1'b0;
      endcase
      if (bad) begin
        if (cnt == 0) first = s;
        cnt++;
      end
      s = {s[1:0], s[2] ^ s[1]};
    end
  endfunction

  task automatic run_test(input int m, input logic noise);
    int loads = 0, steps = 0, cnt, cnt_sa0;
    logic [2:0] first, first_sa0;
    mode = m;
    model(m, fmask, cnt, first);
    model(1, 8'h00, cnt_sa0, first_sa0);
    @(posedge clock); #1 start = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clock); #1;
      start = (noise && k <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      {func_a, func_b, func_cin} = 3'($urandom_range(0, 7));
      #1;
      if (tpg_load) loads++;
      if (tpg_step) steps++;
      check("load_step_overlap", {31'd0, tpg_load & tpg_step}, 32'd0);
      check("done_timing", {31'd0, done}, {31'd0, k == 9});
      check("busy_timing", {30'd0, busy, test_mode}, (k < 9) ? 32'd3 : 32'd0);
      check("cut_mux", {29'd0, cut_a, cut_b, cut_cin},
            {29'd0, test_mode ? tpg : {func_a, func_b, func_cin}});
      if (k == 0)
        check("cleared_on_start", {27'd0, pass, fail_count, ffp}, 32'd0);
    end
    check("load_pulses", loads, 1);
    check("step_pulses", steps, NP - 1);
    check("pass", {31'd0, pass}, {31'd0, cnt == 0});
    check("fail_count", {29'd0, fail_count}, (cnt > 7) ? 32'd7 : cnt);
    check("first_fail", {29'd0, ffp}, {29'd0, first});
    check("sat_fail_count", {31'd0, fail_count1}, (cnt_sa0 > 0) ? 32'd1 : 32'd0);
    check("sat_pass", {31'd0, pass1}, 32'd0);
    @(posedge clock); #2;
    check("done_hold", {27'd0, done, pass, fail_count}, {27'd0, 1'b1, cnt == 0, 3'((cnt > 7) ? 7 : cnt)});
  endtask

  typedef struct {
    logic [2:0] func;
    logic [2:0] exp_cut;
  } vec_t;
  vec_t vecs[8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].func = 3'(7 - i);
      vecs[i].exp_cut = 3'(7 - i);
    end

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    {func_a, func_b, func_cin} = 3'b101;
    #1;
    check("reset_state", {26'd0, test_mode, busy, done, pass, fail_count}, 32'd0);
    check("reset_ffp", {29'd0, ffp}, 32'd0);
    check("idle_mux", {29'd0, cut_a, cut_b, cut_cin}, 32'd5);
    check("idle_strobes", {30'd0, tpg_load, tpg_step}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      {func_a, func_b, func_cin} = vecs[i].func;
      #1;
      check("idle_vec", {29'd0, cut_a, cut_b, cut_cin}, {29'd0, vecs[i].exp_cut});
    end

    run_test(0, 1'b0);
    run_test(1, 1'b0);
    run_test(2, 1'b1);
    run_test(0, 1'b0);

    // reset in the 4th RUN cycle, with a failing CUT so the counter is nonzero
    mode = 1;
    @(posedge clock); #1 start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clock); #1 start = 1'b0;
    end
    #1;
    check("pre_reset_fails", {29'd0, fail_count}, 32'd2);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    #1;
    check("midrun_reset", {25'd0, test_mode, busy, done, tpg_step, pass, fail_count}, 32'd0);
    run_test(0, 1'b0);

    for (int r = 0; r < 15; r++) begin
      fmask = 8'($urandom_range(0, 255));
      run_test(3, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
